// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns.
// Mode and colour are latched only at frame boundaries so a frame is never torn.
module vga_pattern_gen #(
  parameter int CW       = 4,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int CHK_LOG2 = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] color,
  output logic            hsync,
  output logic            vsync,
  output logic            active,
  output logic [9:0]      x,
  output logic [9:0]      y,
  output logic            frame_start,
  output logic [3*CW-1:0] rgb
);

  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]      H_ACT_L  = 10'(H_ACT);
  localparam logic [9:0]      V_ACT_L  = 10'(V_ACT);
  localparam logic [9:0]      HS_BEG   = 10'(H_ACT + H_FP);
  localparam logic [9:0]      HS_END   = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0]      VS_BEG   = 10'(V_ACT + V_FP);
  localparam logic [9:0]      VS_END   = 10'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [9:0]      POS_MAX  = 10'(H_ACT - 16);
  localparam int              BAR_W    = H_ACT / 8;

  logic [DW-1:0]   r_div;
  logic            r_started;
  logic [9:0]      r_h;
  logic [9:0]      r_v;
  logic [9:0]      r_pos;
  logic [1:0]      r_mode;
  logic [3*CW-1:0] r_color;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_active;
  logic [9:0]      r_x;
  logic [9:0]      r_y;
  logic            r_frame_start;
  logic [3*CW-1:0] r_rgb;

  logic            w_tick;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_reload;
  logic            w_active;
  logic [9:0]      w_pos_step;
  logic [7:1]      w_ge;
  logic [2:0]      w_bar;
  logic [3*CW-1:0] w_pix;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);
  assign w_reload   = w_tick && r_started && w_h_last && w_v_last;
  assign w_active   = (r_h < H_ACT_L) && (r_v < V_ACT_L);
  assign w_pos_step = r_pos + 10'd4;

  // Bar index from seven column thresholds instead of a divider.
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_cmp
    assign w_ge[gi] = (r_h >= 10'(gi * BAR_W));
  end

  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++) begin
      w_bar = w_bar + {2'b00, w_ge[k]};
    end
  end

  always_comb begin
    w_pix = r_color;
    case (r_mode)
      2'd0: w_pix = r_color;
      2'd1: w_pix = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
      2'd2: w_pix = (r_h[CHK_LOG2] ^ r_v[CHK_LOG2]) ? r_color : ~r_color;
      2'd3: w_pix = ((r_h >= r_pos) && (r_h <= r_pos + 10'd15)) ? r_color : '0;
      default: w_pix = r_color;
    endcase
  end

  // The first tick after reset only arms scanning, so pixel (0,0) starts there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_started     <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_pos         <= '0;
      r_mode        <= '0;
      r_color       <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_active      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_rgb         <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        r_started <= 1'b1;
        if (r_started) begin
          if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
          end else begin
            r_h <= r_h + 10'd1;
          end
        end
      end
      // Bar position steps with the mode of the frame that just ended.
      if (w_reload) begin
        r_mode  <= mode;
        r_color <= color;
        if (r_mode == 2'd3) begin
          r_pos <= (w_pos_step > POS_MAX) ? 10'd0 : w_pos_step;
        end
      end
      r_hsync       <= !((r_h >= HS_BEG) && (r_h <= HS_END));
      r_vsync       <= !((r_v >= VS_BEG) && (r_v <= VS_END));
      r_active      <= w_active;
      r_x           <= r_h;
      r_y           <= r_v;
      r_frame_start <= r_started && (r_div == '0) && (r_h == '0) && (r_v == '0);
      r_rgb         <= w_active ? w_pix : '0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_frame_start;
  assign rgb         = r_rgb;

endmodule
